// File: rtl/conv_pkg.sv
// Shared definitions for the 3x3 convolution front end: pixel width default,
// window-generator state encoding and window tap indices used by the conv stage.
package conv_pkg;

  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2
  } state_e;

  // Window tap indices, row-major: 1..3 top, 4..6 middle, 7..9 bottom.
  localparam int WIN_1 = 1;
  localparam int WIN_2 = 2;
  localparam int WIN_3 = 3;
  localparam int WIN_4 = 4;
  localparam int WIN_5 = 5;
  localparam int WIN_6 = 6;
  localparam int WIN_7 = 7;
  localparam int WIN_8 = 8;
  localparam int WIN_9 = 9;

endpackage

// File: rtl/conv_line_buffer.sv
// DEPTH-deep pixel delay line: dout is the sample written DEPTH enabled cycles ago.
module conv_line_buffer #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8
) (
  input  logic              clk,
  input  logic              en,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);

  logic [DATA_W-1:0] mem [DEPTH];

  // NOTE: storage arrays carry no reset; stale contents are never observed
  // because a window is only emitted once both delayed rows are refilled.
  always_ff @(posedge clk) begin
    if (en) begin
      mem[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        mem[i] <= mem[i-1];
      end
    end
  end

  assign dout = mem[DEPTH-1];

endmodule

// File: rtl/conv_window_gen.sv
// Raster pixel stream to 3x3 sliding window generator (valid windows only,
// stride 1), registered output with one cycle of latency.
module conv_window_gen
  import conv_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pix_valid,
  input  logic [DATA_W-1:0] pix_in,
  output logic              win_valid,
  output logic [DATA_W-1:0] win_1,
  output logic [DATA_W-1:0] win_2,
  output logic [DATA_W-1:0] win_3,
  output logic [DATA_W-1:0] win_4,
  output logic [DATA_W-1:0] win_5,
  output logic [DATA_W-1:0] win_6,
  output logic [DATA_W-1:0] win_7,
  output logic [DATA_W-1:0] win_8,
  output logic [DATA_W-1:0] win_9,
  output logic              frame_done
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  logic [CW-1:0]     col;
  logic [RW-1:0]     row;
  logic              col_last, row_last, emit;
  logic [DATA_W-1:0] lb0_out, lb1_out;
  logic [DATA_W-1:0] win_r    [3][3];
  logic [DATA_W-1:0] win_next [WIN_1:WIN_9];
  logic [DATA_W-1:0] win_q    [WIN_1:WIN_9];
  state_e            state, state_next;

  assign col_last = (col == CW'(IMG_W - 1));
  assign row_last = (row == RW'(IMG_H - 1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col   <= '0;
      row   <= '0;
      state <= IDLE;
    end else begin
      state <= state_next;
      if (pix_valid) begin
        col <= col_last ? '0 : col + 1'b1;
        if (col_last) row <= row_last ? '0 : row + 1'b1;
      end
    end
  end

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_next = state;
    emit       = 1'b0;
    case (state)
      IDLE: if (pix_valid) state_next = FILL;
      FILL: if (pix_valid && col_last && row == RW'(1)) state_next = RUN;
      RUN: begin
        emit = pix_valid && (row >= RW'(2)) && (col >= CW'(2));
        if (pix_valid && col_last && row_last) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  conv_line_buffer #(.DATA_W(DATA_W), .DEPTH(IMG_W)) u_lb1 (
    .clk (clk),
    .en  (pix_valid),
    .din (pix_in),
    .dout(lb1_out)
  );

  conv_line_buffer #(.DATA_W(DATA_W), .DEPTH(IMG_W)) u_lb0 (
    .clk (clk),
    .en  (pix_valid),
    .din (lb1_out),
    .dout(lb0_out)
  );

  always_ff @(posedge clk) begin
    if (pix_valid) begin
      for (int r = 0; r < 3; r++) begin
        win_r[r][0] <= win_r[r][1];
        win_r[r][1] <= win_r[r][2];
      end
      win_r[0][2] <= lb0_out;
      win_r[1][2] <= lb1_out;
      win_r[2][2] <= pix_in;
    end
  end

  // Window as it will look after this cycle's shift: two held columns plus the incoming one.
  always_comb begin
    win_next[WIN_1] = win_r[0][1];
    win_next[WIN_2] = win_r[0][2];
    win_next[WIN_3] = lb0_out;
    win_next[WIN_4] = win_r[1][1];
    win_next[WIN_5] = win_r[1][2];
    win_next[WIN_6] = lb1_out;
    win_next[WIN_7] = win_r[2][1];
    win_next[WIN_8] = win_r[2][2];
    win_next[WIN_9] = pix_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_valid  <= 1'b0;
      frame_done <= 1'b0;
      for (int k = WIN_1; k <= WIN_9; k++) win_q[k] <= '0;
    end else begin
      win_valid  <= emit;
      frame_done <= emit && col_last && row_last;
      for (int k = WIN_1; k <= WIN_9; k++) win_q[k] <= emit ? win_next[k] : '0;
    end
  end

  assign win_1 = win_q[WIN_1];
  assign win_2 = win_q[WIN_2];
  assign win_3 = win_q[WIN_3];
  assign win_4 = win_q[WIN_4];
  assign win_5 = win_q[WIN_5];
  assign win_6 = win_q[WIN_6];
  assign win_7 = win_q[WIN_7];
  assign win_8 = win_q[WIN_8];
  assign win_9 = win_q[WIN_9];

endmodule

// File: tb/tb_conv_window_gen.sv
// Directed bench for conv_window_gen: a 4x4 instance driven from a vector table
// and an 8x8 instance driven frame-by-frame against a coordinate-based model.
module tb_conv_window_gen;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pv4 = 1'b0, pv8 = 1'b0;
  logic [7:0] px4 = '0, px8 = '0;

  logic       v4, d4, v8, d8;
  logic [7:0] a1, a2, a3, a4, a5, a6, a7, a8, a9;
  logic [7:0] b1, b2, b3, b4, b5, b6, b7, b8, b9;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  conv_window_gen #(.DATA_W(8), .IMG_W(4), .IMG_H(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .pix_valid(pv4), .pix_in(px4), .win_valid(v4),
    .win_1(a1), .win_2(a2), .win_3(a3), .win_4(a4), .win_5(a5),
    .win_6(a6), .win_7(a7), .win_8(a8), .win_9(a9), .frame_done(d4)
  );

  conv_window_gen #(.DATA_W(8), .IMG_W(8), .IMG_H(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .pix_valid(pv8), .pix_in(px8), .win_valid(v8),
    .win_1(b1), .win_2(b2), .win_3(b3), .win_4(b4), .win_5(b5),
    .win_6(b6), .win_7(b7), .win_8(b8), .win_9(b9), .frame_done(d8)
  );

  typedef struct {
    logic [7:0]  pix;
    logic        exp_valid;
    logic        exp_done;
    logic [71:0] exp_win;
    int          exp_sum;
  } vec_t;

  vec_t tbl [16];

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [71:0] win_of(input int sel);
    return (sel == 0) ? {a1, a2, a3, a4, a5, a6, a7, a8, a9}
                      : {b1, b2, b3, b4, b5, b6, b7, b8, b9};
  endfunction

  function automatic logic valid_of(input int sel);
    return (sel == 0) ? v4 : v8;
  endfunction

  function automatic logic done_of(input int sel);
    return (sel == 0) ? d4 : d8;
  endfunction

  // One clock: drive at the falling edge, leave outputs settled 1 time unit after the rising edge.
  task automatic step(input int sel, input logic v, input logic [7:0] p);
    @(negedge clk);
    if (sel == 0) begin pv4 = v; px4 = p; pv8 = 1'b0; end
    else          begin pv8 = v; px8 = p; pv4 = 1'b0; end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] pixval(input int w, input int base, input bit ones,
                                        input int r, input int c);
    return ones ? 8'hFF : 8'((base + r * w + c) % 256);
  endfunction

  // Streams one frame and checks every output cycle against the model window.
  task automatic run_frame(input int sel, input int w, input int h, input int base,
                           input bit ones, input bit gaps, inout int nwin, inout int ndone);
    logic [71:0] exp;
    logic        ev, ed;
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        if (gaps) begin
          step(sel, 1'b0, 8'h5A);
          check($sformatf("gap_valid s%0d r%0d c%0d", sel, r, c), 72'(valid_of(sel)), 72'(0));
          check($sformatf("gap_win s%0d r%0d c%0d", sel, r, c), win_of(sel), 72'(0));
        end
        step(sel, 1'b1, pixval(w, base, ones, r, c));
        ev  = (r >= 2) && (c >= 2);
        ed  = (r == h - 1) && (c == w - 1);
        exp = '0;
        if (ev) begin
          for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
              exp = {exp[63:0], pixval(w, base, ones, r - 2 + i, c - 2 + j)};
        end
        check($sformatf("valid s%0d r%0d c%0d", sel, r, c), 72'(valid_of(sel)), 72'(ev));
        check($sformatf("win s%0d r%0d c%0d", sel, r, c), win_of(sel), exp);
        check($sformatf("done s%0d r%0d c%0d", sel, r, c), 72'(done_of(sel)), 72'(ed));
        if (valid_of(sel)) nwin++;
        if (done_of(sel))  ndone++;
      end
    end
  endtask

  initial begin
    int nwin, ndone, sum;
    logic [71:0] w;

    for (int i = 0; i < 16; i++) begin
      tbl[i].pix = 8'(i + 1);
      tbl[i].exp_valid = 1'b0;
      tbl[i].exp_done  = 1'b0;
      tbl[i].exp_win   = '0;
      tbl[i].exp_sum   = 0;
    end
    tbl[10].exp_valid = 1'b1; tbl[10].exp_sum = 54;
    tbl[10].exp_win   = {8'd1, 8'd2, 8'd3, 8'd5, 8'd6, 8'd7, 8'd9, 8'd10, 8'd11};
    tbl[11].exp_valid = 1'b1; tbl[11].exp_sum = 63;
    tbl[11].exp_win   = {8'd2, 8'd3, 8'd4, 8'd6, 8'd7, 8'd8, 8'd10, 8'd11, 8'd12};
    tbl[14].exp_valid = 1'b1; tbl[14].exp_sum = 90;
    tbl[14].exp_win   = {8'd5, 8'd6, 8'd7, 8'd9, 8'd10, 8'd11, 8'd13, 8'd14, 8'd15};
    tbl[15].exp_valid = 1'b1; tbl[15].exp_sum = 99; tbl[15].exp_done = 1'b1;
    tbl[15].exp_win   = {8'd6, 8'd7, 8'd8, 8'd10, 8'd11, 8'd12, 8'd14, 8'd15, 8'd16};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid4", 72'(v4), 72'(0));
    check("rst_done4", 72'(d4), 72'(0));
    check("rst_win4", win_of(0), 72'(0));
    check("rst_valid8", 72'(v8), 72'(0));
    check("rst_win8", win_of(1), 72'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // 4x4 ramp 1..16, continuous, then again with a gap before every pixel
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < 16; i++) begin
        if (pass == 1) begin
          step(0, 1'b0, 8'hC3);
          check($sformatf("tbl_gap_valid %0d", i), 72'(v4), 72'(0));
          check($sformatf("tbl_gap_done %0d", i), 72'(d4), 72'(0));
        end
        step(0, 1'b1, tbl[i].pix);
        w = win_of(0);
        check($sformatf("tbl_valid p%0d i%0d", pass, i), 72'(v4), 72'(tbl[i].exp_valid));
        check($sformatf("tbl_win p%0d i%0d", pass, i), w, tbl[i].exp_win);
        check($sformatf("tbl_done p%0d i%0d", pass, i), 72'(d4), 72'(tbl[i].exp_done));
        if (tbl[i].exp_valid) begin
          sum = 0;
          for (int k = 0; k < 9; k++) sum += int'(w[k*8 +: 8]);
          check($sformatf("tbl_sum p%0d i%0d", pass, i), 72'(sum), 72'(tbl[i].exp_sum));
        end
      end
    end

    // All-ones pixels on the 4x4 instance
    nwin = 0; ndone = 0;
    run_frame(0, 4, 4, 0, 1'b1, 1'b0, nwin, ndone);
    check("ones_count", 72'(nwin), 72'(4));
    check("ones_done", 72'(ndone), 72'(1));

    // 8x8 ramp, two frames back-to-back
    nwin = 0; ndone = 0;
    run_frame(1, 8, 8, 0, 1'b0, 1'b0, nwin, ndone);
    run_frame(1, 8, 8, 0, 1'b0, 1'b0, nwin, ndone);
    check("b2b_count", 72'(nwin), 72'(72));
    check("b2b_done", 72'(ndone), 72'(2));

    // Reset after pixel 20 of an 8x8 frame (pixel 19 was at row 2, col 3: window present)
    for (int i = 0; i < 20; i++) step(1, 1'b1, 8'(200 + i));
    check("pre_rst_valid", 72'(v8), 72'(1));
    @(negedge clk);
    pv8 = 1'b1; px8 = 8'hEE;
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 72'(v8), 72'(0));
    check("mid_rst_win", win_of(1), 72'(0));
    check("mid_rst_done", 72'(d8), 72'(0));
    repeat (2) @(posedge clk);
    #1;
    check("held_rst_valid", 72'(v8), 72'(0));
    check("held_rst_win", win_of(1), 72'(0));
    @(negedge clk);
    pv8 = 1'b0;
    rst_n = 1'b1;
    nwin = 0; ndone = 0;
    run_frame(1, 8, 8, 100, 1'b0, 1'b0, nwin, ndone);
    check("post_rst_count", 72'(nwin), 72'(36));
    check("post_rst_done", 72'(ndone), 72'(1));

    // Idle cycle after the frame: nothing should be emitted
    step(1, 1'b0, 8'h00);
    check("idle_valid", 72'(v8), 72'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
